syx_bank_decoder: RTL

Parametrised bank-select decoder and write-strobe sequencer between the SysEx/CPU parameter receiver and the synth parameter banks (env, osc, m1, m2, com, plus future banks). It synchronises the asynchronous `data_ready` flag and latches the bank address on its rising edge. It then drives a one-hot bank select, and after a programmable settle delay issues a single-cycle `write` strobe. It also generalises the fixed 5-bank decoder to N banks with a configurable enable mask, and adds busy/overrun/unmapped error reporting and a completed-write counter.

---
 rtl/synth_bank_pkg.sv | 20 ++
 rtl/sync_rise_det.sv | 32 +++
 rtl/syx_bank_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/synth_bank_pkg.sv
// Shared types and constants for the synth parameter bank decoder.
// Bank indices name the fixed banks of the original five-bank map.
package synth_bank_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StStrobe,
        StWaitLow
    } bank_state_e;

    localparam int unsigned BANK_ENV = 0;
    localparam int unsigned BANK_OSC = 1;
    localparam int unsigned BANK_M1  = 2;
    localparam int unsigned BANK_M2  = 3;
    localparam int unsigned BANK_COM = 5;

    localparam logic [7:0] BANK_EN_DEFAULT = 8'b0010_1111;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for an asynchronous level, with a registered
// single-cycle pulse on each synchronised rising edge.
module sync_rise_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;
    logic              rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            last_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~last_q;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/syx_bank_decoder.sv
// Bank-select decoder and delayed write-strobe sequencer between the parameter
// receiver and the synth parameter banks, with sticky error flags and a write counter.
module syx_bank_decoder
    import synth_bank_pkg::*;
#(
    parameter int unsigned                 BANK_W      = 3,
    parameter int unsigned                 NUM_BANKS   = 8,
    parameter logic [NUM_BANKS-1:0]        BANK_EN     = NUM_BANKS'(BANK_EN_DEFAULT),
    parameter int unsigned                 SYNC_STAGES = 2,
    parameter int unsigned                 WRITE_DELAY = 2,
    parameter int unsigned                 CNT_W       = 16
) (
    input  logic                 CLOCK_25,
    input  logic                 iRST,
    input  logic                 data_ready,
    input  logic [BANK_W-1:0]    bank_adr,
    input  logic                 err_clr,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic                 write,
    output logic                 busy,
    output logic                 err_unmapped,
    output logic                 err_overrun,
    output logic [CNT_W-1:0]     wr_count
);

    localparam int unsigned DLY_W = (WRITE_DELAY > 1) ? $clog2(WRITE_DELAY) : 1;

    logic                 ready_level;
    logic                 ready_rise;
    logic [BANK_W-1:0]    adr_q;
    bank_state_e          state_q, state_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [NUM_BANKS-1:0] sel_q, sel_d;
    logic                 mapped_q, mapped_d;
    logic                 write_q, write_d;
    logic                 unm_q, unm_d;
    logic                 ovr_q, ovr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_BANKS-1:0] req_sel;
    logic                 req_mapped;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_ready_sync (
        .clk      (CLOCK_25),
        .rst      (iRST),
        .async_in (data_ready),
        .level    (ready_level),
        .rise     (ready_rise)
    );

    // Out-of-range addresses never match any index, so they decode to all-zero.
    always_comb begin
        req_sel = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (BANK_EN[i] && (adr_q == BANK_W'(i))) begin
                req_sel[i] = 1'b1;
            end
        end
    end

    assign req_mapped = |req_sel;

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        sel_d    = sel_q;
        mapped_d = mapped_q;
        write_d  = 1'b0;
        cnt_d    = cnt_q;
        unm_d    = unm_q & ~err_clr;
        ovr_d    = ovr_q & ~err_clr;
        unique case (state_q)
            StIdle: begin
                if (ready_rise) begin
                    state_d  = StSettle;
                    sel_d    = req_sel;
                    mapped_d = req_mapped;
                    dly_d    = DLY_W'(WRITE_DELAY - 1);
                    if (!req_mapped) unm_d = 1'b1;
                end
            end
            StSettle: begin
                if (ready_rise) ovr_d = 1'b1;
                if (dly_q == '0) begin
                    state_d = StStrobe;
                    write_d = mapped_q;
                    if (mapped_q) cnt_d = cnt_q + 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            StStrobe: begin
                if (ready_rise) ovr_d = 1'b1;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!ready_level) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            adr_q    <= '0;
            state_q  <= StIdle;
            dly_q    <= '0;
            sel_q    <= '0;
            mapped_q <= 1'b0;
            write_q  <= 1'b0;
            unm_q    <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            adr_q    <= bank_adr;
            state_q  <= state_d;
            dly_q    <= dly_d;
            sel_q    <= sel_d;
            mapped_q <= mapped_d;
            write_q  <= write_d;
            unm_q    <= unm_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bank_sel     = sel_q;
    assign write        = write_q;
    assign busy         = (state_q != StIdle);
    assign err_unmapped = unm_q;
    assign err_overrun  = ovr_q;
    assign wr_count     = cnt_q;

endmodule
